// File: rtl/recip_pkg.sv
// Shared types and default widths for the reciprocal frequency counter.
//   gate_state_e : gate generator FSM encoding
//   N_W_DEF      : period / edge count width
//   TO_W_DEF     : timeout counter width
package recip_pkg;

    localparam int unsigned N_W_DEF  = 16;
    localparam int unsigned TO_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_GATE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } gate_state_e;

endpackage

// File: rtl/sig_edge_sync.sv
// Brings an asynchronous input into the ref_clk domain and flags its rising edges.
//   ref_clk : reference clock
//   reset   : synchronous, active-low
//   sig_in  : asynchronous input
//   rise_c  : one-cycle pulse per rising edge of sig_in (combinational from flops)
module sig_edge_sync (
    input  logic ref_clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise_c
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/recip_gate_gen.sv
// Gate window generator for the reciprocal frequency counter. The gate opens on
// a rising edge of sig_in and closes after n_periods further rising edges, so the
// downstream counter integrates ref_clk over whole input periods.
//   ref_clk     : reference clock
//   reset       : synchronous, active-low
//   sig_in      : signal under test (asynchronous)
//   start       : request one measurement (sampled in IDLE only)
//   auto_rearm  : re-arm after holdoff instead of returning to IDLE
//   n_periods   : input periods per gate, captured at start (0 means 1)
//   sample_gate : measurement window (registered)
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse on normal gate close
//   timeout     : one-cycle pulse on dead-input abort
//   edge_count  : rises counted in current/last gate
module recip_gate_gen
    import recip_pkg::*;
#(
    parameter int unsigned N_W         = N_W_DEF,
    parameter int unsigned TO_W        = TO_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000000,
    parameter int unsigned HOLDOFF_CYC = 4
) (
    input  logic           ref_clk,
    input  logic           reset,
    input  logic           sig_in,
    input  logic           start,
    input  logic           auto_rearm,
    input  logic [N_W-1:0] n_periods,
    output logic           sample_gate,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [N_W-1:0] edge_count
);

    localparam int unsigned HO_W = (HOLDOFF_CYC > 2) ? $clog2(HOLDOFF_CYC) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYC - 32'd1);

    gate_state_e     state_q;
    gate_state_e     state_d;
    logic [N_W-1:0]  n_lat_q;
    logic [N_W-1:0]  n_lat_d;
    logic [N_W-1:0]  edge_q;
    logic [N_W-1:0]  edge_d;
    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_d;
    logic [HO_W-1:0] hold_q;
    logic [HO_W-1:0] hold_d;
    logic            gate_q;
    logic            gate_d;
    logic            busy_q;
    logic            done_q;
    logic            done_d;
    logic            timeout_q;
    logic            timeout_d;

    logic            rise_c;
    logic            to_last_c;
    logic [N_W:0]    edge_plus_c;
    logic [N_W-1:0]  edge_sat_c;
    logic            last_edge_c;

    sig_edge_sync u_sync (
        .ref_clk (ref_clk),
        .reset   (reset),
        .sig_in  (sig_in),
        .rise_c  (rise_c)
    );

    // Edge count arithmetic is one bit wider so the close compare is exact even at all-ones.
    assign edge_plus_c = {1'b0, edge_q} + (N_W + 1)'(1);
    assign edge_sat_c  = (&edge_q) ? edge_q : edge_plus_c[N_W-1:0];
    assign last_edge_c = (edge_plus_c == {1'b0, n_lat_q});
    assign to_last_c   = (to_q == TO_LAST);

    // Next-state and registered-output logic; a rise always beats the timeout terminal count.
    always_comb begin
        state_d   = state_q;
        n_lat_d   = n_lat_q;
        edge_d    = edge_q;
        to_d      = to_q;
        hold_d    = hold_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_lat_d = (n_periods == '0) ? N_W'(1) : n_periods;
                    to_d    = '0;
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (rise_c) begin
                    gate_d  = 1'b1;
                    edge_d  = '0;
                    to_d    = '0;
                    state_d = ST_GATE;
                end else if (to_last_c) begin
                    timeout_d = 1'b1;
                    hold_d    = '0;
                    state_d   = ST_HOLDOFF;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_GATE: begin
                if (rise_c) begin
                    edge_d = edge_sat_c;
                    to_d   = '0;
                    if (last_edge_c) begin
                        gate_d  = 1'b0;
                        done_d  = 1'b1;
                        hold_d  = '0;
                        state_d = ST_HOLDOFF;
                    end
                end else if (to_last_c) begin
                    gate_d    = 1'b0;
                    timeout_d = 1'b1;
                    hold_d    = '0;
                    state_d   = ST_HOLDOFF;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_HOLDOFF: begin
                // Gate stays low here so the counter can latch its result.
                if (hold_q == HO_LAST) begin
                    to_d    = '0;
                    state_d = auto_rearm ? ST_ARM : ST_IDLE;
                end else begin
                    hold_d = hold_q + HO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            n_lat_q   <= '0;
            edge_q    <= '0;
            to_q      <= '0;
            hold_q    <= '0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_lat_q   <= n_lat_d;
            edge_q    <= edge_d;
            to_q      <= to_d;
            hold_q    <= hold_d;
            gate_q    <= gate_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign sample_gate = gate_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign edge_count  = edge_q;

endmodule

// File: tb/tb_recip_gate_gen.sv
module tb_recip_gate_gen;

    localparam int unsigned N_W     = 16;
    localparam int unsigned TO_W    = 32;
    localparam int          TIMEOUT = 1000;
    localparam int          HOLDOFF = 4;
    localparam int          LIMIT   = 20000;

    logic           ref_clk;
    logic           reset;
    logic           sig_in;
    logic           start;
    logic           auto_rearm;
    logic [N_W-1:0] n_periods;
    logic           sample_gate;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [N_W-1:0] edge_count;

    recip_gate_gen #(
        .N_W         (N_W),
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT),
        .HOLDOFF_CYC (HOLDOFF)
    ) dut (
        .ref_clk     (ref_clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .start       (start),
        .auto_rearm  (auto_rearm),
        .n_periods   (n_periods),
        .sample_gate (sample_gate),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .edge_count  (edge_count)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Expected outcome of one gate attempt.
    typedef struct {
        bit is_done;
        int edges;
        int gate_len;
        bit arm_to;
        bit rearm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_seen = 0;
    int   last_edges = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        checks++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, LIMIT);
    endtask

    // Signal-under-test generator: a burst of sig_rises periods of sig_lo low / sig_hi high.
    int sig_lo = 5;
    int sig_hi = 5;
    int sig_rises = 0;
    bit sig_req = 0;
    bit sig_active = 0;
    bit sig_stop = 0;

    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge ref_clk);
            if (sig_req) begin
                sig_active = 1;
                sig_req = 0;
                for (int r = 0; r < sig_rises && !sig_stop; r++) begin
                    repeat (sig_lo) @(negedge ref_clk);
                    sig_in = 1'b1;
                    repeat (sig_hi) @(negedge ref_clk);
                    sig_in = 1'b0;
                end
                sig_active = 0;
            end
        end
    end

    // Monitor: measures gate length, pops an expectation on every done/timeout pulse.
    int   gl = 0;
    int   gap = 1000;
    int   bcnt = 0;
    int   post_cnt = 0;
    bit   post_on = 0;
    bit   post_rearm = 0;
    bit   prev_gate = 0;
    exp_t e;

    always begin
        @(posedge ref_clk);
        #1;
        if (!reset) begin
            gl = 0; gap = 1000; bcnt = 0; post_on = 0; prev_gate = 0;
        end else begin
            if (done || timeout) begin
                check("done_timeout_exclusive", int'(done & timeout), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(done | timeout), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_done", int'(done), int'(e.is_done));
                    check("edge_count", int'(edge_count), e.edges);
                    check("gate_low_at_pulse", int'(sample_gate), 0);
                    checks++;
                    if (gl >= e.gate_len - 1 && gl <= e.gate_len + 1) passes++;
                    else $display("FAIL gate_len: got %0d expected %0d +/-1", gl, e.gate_len);
                    if (e.arm_to) check("arm_timeout_latency", bcnt, TIMEOUT);
                    post_on = 1;
                    post_cnt = 0;
                    post_rearm = e.rearm;
                    done_seen++;
                end
                gl = 0;
            end else if (post_on) begin
                post_cnt++;
                if (post_cnt == HOLDOFF) begin
                    check("busy_after_holdoff", int'(busy), int'(post_rearm));
                    post_on = 0;
                end
            end
            if (sample_gate) begin
                if (!prev_gate) check("gap_ge_holdoff", int'(gap >= HOLDOFF), 1);
                gl++;
                gap = 0;
            end else begin
                gap++;
            end
            prev_gate = sample_gate;
            bcnt = busy ? bcnt + 1 : 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ref_clk);
    endtask

    task automatic wait_busy_low(input string tag);
        int k = 0;
        while (busy && k < LIMIT) begin @(negedge ref_clk); k++; end
        check({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    task automatic wait_sig_idle();
        int k = 0;
        while ((sig_req || sig_active) && k < LIMIT) begin @(negedge ref_clk); k++; end
        if (k == LIMIT) bound_fail("sig_idle");
    endtask

    // One measurement: model the outcome from the period count, then drive it.
    task automatic measure(input int n, input int lo, input int hi, input int rises);
        exp_t x;
        int   n_eff = (n == 0) ? 1 : n;
        int   per = lo + hi;
        x.rearm = 0;
        x.arm_to = (rises == 0);
        if (rises == 0) begin
            x.is_done = 0; x.edges = last_edges; x.gate_len = 0;
        end else if (rises - 1 >= n_eff) begin
            x.is_done = 1; x.edges = n_eff; x.gate_len = n_eff * per;
        end else begin
            x.is_done = 0; x.edges = rises - 1; x.gate_len = (rises - 1) * per + TIMEOUT;
        end
        last_edges = x.edges;
        exp_q.push_back(x);

        n_periods = N_W'(n);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        sig_lo = lo; sig_hi = hi; sig_rises = rises; sig_req = 1;
        // A start and a new period count while busy must both be ignored.
        n_periods = N_W'($urandom_range(20, 1));
        cyc(3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_busy_low("measure");
        wait_sig_idle();
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, lo, hi, r, base, k;
        reset = 1'b0;
        start = 1'b0;
        auto_rearm = 1'b0;
        n_periods = '0;
        repeat (3) @(posedge ref_clk);
        #1;
        check("rst_sample_gate", int'(sample_gate), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_edge_count", int'(edge_count), 0);
        @(negedge ref_clk);
        reset = 1'b1;
        cyc(3);

        measure(10, 10, 10, 11);
        measure(0, 15, 15, 2);
        measure(3, 5, 5, 0);
        measure(10, 6, 6, 4);

        for (int t = 0; t < 16; t++) begin
            n  = $urandom_range(8, 0);
            lo = $urandom_range(20, 2);
            hi = $urandom_range(20, 2);
            r  = (n == 0) ? 2 : n + 1;
            if ($urandom_range(3, 0) == 0) r = $urandom_range((n == 0) ? 1 : n, 0);
            measure(n, lo, hi, r);
        end

        // Back-to-back gates with auto re-arm; the third holdoff returns to IDLE.
        auto_rearm = 1'b1;
        base = done_seen;
        for (int g = 0; g < 3; g++) begin
            exp_t x;
            x.is_done = 1; x.edges = 5; x.gate_len = 50; x.arm_to = 0; x.rearm = (g < 2);
            exp_q.push_back(x);
        end
        last_edges = 5;
        n_periods = N_W'(5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        n_periods = N_W'(2);
        sig_lo = 5; sig_hi = 5; sig_rises = 10000; sig_req = 1;
        k = 0;
        while (done_seen < base + 3 && k < LIMIT) begin
            start = (k % 37 == 20);
            @(negedge ref_clk);
            k++;
        end
        start = 1'b0;
        auto_rearm = 1'b0;
        if (k == LIMIT) bound_fail("auto_rearm_gates");
        wait_busy_low("auto");
        sig_stop = 1;
        wait_sig_idle();
        sig_stop = 0;
        cyc(2);

        // Reset pulse in the middle of a gate.
        n_periods = N_W'(10);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        sig_lo = 10; sig_hi = 10; sig_rises = 100; sig_req = 1;
        k = 0;
        while (!sample_gate && k < LIMIT) begin @(negedge ref_clk); k++; end
        if (k == LIMIT) bound_fail("gate_open");
        cyc(30);
        check("pre_rst_edge_count_nonzero", int'(edge_count != 0), 1);
        reset = 1'b0;
        @(posedge ref_clk);
        #1;
        check("midrst_sample_gate", int'(sample_gate), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_edge_count", int'(edge_count), 0);
        @(negedge ref_clk);
        reset = 1'b1;
        last_edges = 0;
        cyc(50);
        check("post_rst_idle_busy", int'(busy), 0);
        check("post_rst_gate", int'(sample_gate), 0);
        sig_stop = 1;
        wait_sig_idle();
        sig_stop = 0;
        cyc(5);

        check("pending_expectations", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
